// File: rtl/picorv_ahb_pkg.sv
// Shared AHB encodings and controller state type for the PicoRV32 AHB-Lite master.
package picorv_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    localparam logic [1:0] HRESP_RETRY = 2'b10;
    localparam logic [1:0] HRESP_SPLIT = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/picorv_ahb_lite_master.sv
// Single-transfer AHB master: takes one adapter request, arbitrates, runs one
// NONSEQ/SINGLE transfer with RETRY/SPLIT re-issue, and returns data or error.
module picorv_ahb_lite_master
    import picorv_ahb_pkg::*;
#(
    parameter int          RETRY_LIMIT   = 15,
    parameter logic [3:0]  HPROT_DEFAULT = 4'b0011
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_ahb_valid,
    input  logic        mem_ahb_write,
    input  logic        mem_ahb_read,
    input  logic [31:0] mem_ahb_addr,
    input  logic [31:0] mem_ahb_wdata,
    input  logic [2:0]  mem_ahb_size,
    input  logic [3:0]  mem_ahb_prot,
    input  logic        mem_ahb_lock,
    output logic        mem_ahb_ready,
    output logic [31:0] mem_ahb_rdata,
    output logic        mem_ahb_err,
    output logic        hbusreq,
    output logic        hlock,
    input  logic        hgrant,
    output logic [1:0]  htrans,
    output logic [31:0] haddr,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic [3:0]  hprot,
    output logic [31:0] hwdata,
    input  logic [31:0] hrdata,
    input  logic        hready,
    input  logic [1:0]  hresp
);

    localparam logic [7:0] RETRY_LIMIT_C = 8'(RETRY_LIMIT);

    // Sizes above a word are never aligned, so they fall out as illegal here too.
    function automatic logic is_aligned(input logic [2:0] size, input logic [1:0] addr_lo);
        logic ok;
        case (size)
            HSIZE_BYTE: ok = 1'b1;
            HSIZE_HALF: ok = ~addr_lo[0];
            HSIZE_WORD: ok = (addr_lo == 2'b00);
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

    state_t      state_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [2:0]  size_r;
    logic        write_r;
    logic [3:0]  prot_r;
    logic        lock_r;
    logic [7:0]  retry_cnt_r;

    logic        req_legal_s;
    logic        retry_hit_s;

    assign req_legal_s = (mem_ahb_read ^ mem_ahb_write) && is_aligned(mem_ahb_size, mem_ahb_addr[1:0]);
    assign retry_hit_s = (retry_cnt_r >= RETRY_LIMIT_C);

    // Request/arbitration/transfer state machine with all bus and adapter outputs registered.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r       <= ST_IDLE;
            addr_r        <= 32'h0000_0000;
            wdata_r       <= 32'h0000_0000;
            size_r        <= HSIZE_WORD;
            write_r       <= 1'b0;
            prot_r        <= 4'h0;
            lock_r        <= 1'b0;
            retry_cnt_r   <= 8'h00;
            hbusreq       <= 1'b0;
            hlock         <= 1'b0;
            htrans        <= HTRANS_IDLE;
            haddr         <= 32'h0000_0000;
            hwrite        <= 1'b0;
            hsize         <= HSIZE_WORD;
            hburst        <= HBURST_SINGLE;
            hprot         <= HPROT_DEFAULT;
            hwdata        <= 32'h0000_0000;
            mem_ahb_ready <= 1'b0;
            mem_ahb_rdata <= 32'h0000_0000;
            mem_ahb_err   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    mem_ahb_ready <= 1'b0;
                    mem_ahb_err   <= 1'b0;
                    if (mem_ahb_valid) begin
                        if (req_legal_s) begin
                            addr_r      <= mem_ahb_addr;
                            wdata_r     <= mem_ahb_wdata;
                            size_r      <= mem_ahb_size;
                            write_r     <= mem_ahb_write;
                            prot_r      <= mem_ahb_prot;
                            lock_r      <= mem_ahb_lock;
                            retry_cnt_r <= 8'h00;
                            hbusreq     <= 1'b1;
                            hlock       <= mem_ahb_lock;
                            state_r     <= ST_REQ;
                        end else begin
                            mem_ahb_ready <= 1'b1;
                            mem_ahb_err   <= 1'b1;
                            state_r       <= ST_DONE;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    hbusreq <= 1'b1;
                    hlock   <= lock_r;
                    if (hgrant && hready) begin
                        htrans  <= HTRANS_NONSEQ;
                        haddr   <= addr_r;
                        hwrite  <= write_r;
                        hsize   <= size_r;
                        hburst  <= HBURST_SINGLE;
                        hprot   <= {HPROT_DEFAULT[3:1], prot_r[0]};
                        state_r <= ST_ADDR;
                    end else begin
                        state_r <= ST_REQ;
                    end
                end
                ST_ADDR: begin
                    if (hready) begin
                        htrans  <= HTRANS_IDLE;
                        hbusreq <= 1'b0;
                        hlock   <= 1'b0;
                        hwdata  <= wdata_r;
                        state_r <= ST_DATA;
                    end else begin
                        state_r <= ST_ADDR;
                    end
                end
                ST_DATA: begin
                    // hready low with non-OKAY hresp is the first half of a two-cycle response.
                    if (hready) begin
                        case (hresp)
                            HRESP_OKAY: begin
                                if (!write_r) begin
                                    mem_ahb_rdata <= hrdata;
                                end else begin
                                    mem_ahb_rdata <= mem_ahb_rdata;
                                end
                                mem_ahb_ready <= 1'b1;
                                mem_ahb_err   <= 1'b0;
                                state_r       <= ST_DONE;
                            end
                            HRESP_ERROR: begin
                                mem_ahb_ready <= 1'b1;
                                mem_ahb_err   <= 1'b1;
                                state_r       <= ST_DONE;
                            end
                            HRESP_RETRY, HRESP_SPLIT: begin
                                if (retry_hit_s) begin
                                    mem_ahb_ready <= 1'b1;
                                    mem_ahb_err   <= 1'b1;
                                    state_r       <= ST_DONE;
                                end else begin
                                    if (retry_cnt_r != 8'hFF) begin
                                        retry_cnt_r <= retry_cnt_r + 8'h01;
                                    end else begin
                                        retry_cnt_r <= retry_cnt_r;
                                    end
                                    hbusreq <= 1'b1;
                                    hlock   <= lock_r;
                                    state_r <= ST_REQ;
                                end
                            end
                            default: begin
                                state_r <= ST_DATA;
                            end
                        endcase
                    end else begin
                        state_r <= ST_DATA;
                    end
                end
                ST_DONE: begin
                    mem_ahb_ready <= 1'b0;
                    mem_ahb_err   <= 1'b0;
                    state_r       <= ST_IDLE;
                end
                default: begin
                    mem_ahb_ready <= 1'b0;
                    mem_ahb_err   <= 1'b0;
                    state_r       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_picorv_ahb_lite_master.sv
// Directed self-checking bench for picorv_ahb_lite_master (instance built with RETRY_LIMIT=2).
module tb_picorv_ahb_lite_master;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_ahb_valid, mem_ahb_write, mem_ahb_read, mem_ahb_lock;
    logic [31:0] mem_ahb_addr, mem_ahb_wdata;
    logic [2:0]  mem_ahb_size;
    logic [3:0]  mem_ahb_prot;
    logic        mem_ahb_ready, mem_ahb_err;
    logic [31:0] mem_ahb_rdata;
    logic        hbusreq, hlock, hgrant, hwrite, hready;
    logic [1:0]  htrans, hresp;
    logic [31:0] haddr, hwdata, hrdata;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    picorv_ahb_lite_master #(.RETRY_LIMIT(2), .HPROT_DEFAULT(4'b0011)) dut (
        .clk(clk), .resetn(resetn),
        .mem_ahb_valid(mem_ahb_valid), .mem_ahb_write(mem_ahb_write), .mem_ahb_read(mem_ahb_read),
        .mem_ahb_addr(mem_ahb_addr), .mem_ahb_wdata(mem_ahb_wdata), .mem_ahb_size(mem_ahb_size),
        .mem_ahb_prot(mem_ahb_prot), .mem_ahb_lock(mem_ahb_lock),
        .mem_ahb_ready(mem_ahb_ready), .mem_ahb_rdata(mem_ahb_rdata), .mem_ahb_err(mem_ahb_err),
        .hbusreq(hbusreq), .hlock(hlock), .hgrant(hgrant),
        .htrans(htrans), .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
        .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic rd, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] size,
                         input logic [3:0] prot, input logic lock);
        mem_ahb_valid = 1'b1;
        mem_ahb_write = wr;
        mem_ahb_read  = rd;
        mem_ahb_addr  = addr;
        mem_ahb_wdata = wdata;
        mem_ahb_size  = size;
        mem_ahb_prot  = prot;
        mem_ahb_lock  = lock;
    endtask

    // Starts in REQ with grant available; ends one edge after the data-phase response.
    task automatic attempt(input logic [1:0] resp, input logic [31:0] addr);
        step();
        check_eq("att_htrans_nonseq", 32'(htrans), 32'h2);
        check_eq("att_haddr", haddr, addr);
        step();
        check_eq("att_htrans_data_idle", 32'(htrans), 32'h0);
        if (resp != 2'b00) begin
            hready = 1'b0;
            hresp  = resp;
            step();
            check_eq("att_htrans_resp1", 32'(htrans), 32'h0);
            hready = 1'b1;
            step();
            hresp = 2'b00;
        end else begin
            step();
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_hbusreq"}, 32'(hbusreq), 32'h0);
        check_eq({tag, "_hlock"},   32'(hlock),   32'h0);
        check_eq({tag, "_htrans"},  32'(htrans),  32'h0);
        check_eq({tag, "_haddr"},   haddr,        32'h0);
        check_eq({tag, "_hwrite"},  32'(hwrite),  32'h0);
        check_eq({tag, "_hsize"},   32'(hsize),   32'h2);
        check_eq({tag, "_hburst"},  32'(hburst),  32'h0);
        check_eq({tag, "_hprot"},   32'(hprot),   32'h3);
        check_eq({tag, "_hwdata"},  hwdata,       32'h0);
        check_eq({tag, "_ready"},   32'(mem_ahb_ready), 32'h0);
        check_eq({tag, "_rdata"},   mem_ahb_rdata, 32'h0);
        check_eq({tag, "_err"},     32'(mem_ahb_err), 32'h0);
    endtask

    initial begin
        resetn = 1'b0;
        mem_ahb_valid = 1'b0; mem_ahb_write = 1'b0; mem_ahb_read = 1'b0; mem_ahb_lock = 1'b0;
        mem_ahb_addr = 32'h0; mem_ahb_wdata = 32'h0; mem_ahb_size = 3'h2; mem_ahb_prot = 4'h0;
        hgrant = 1'b1; hready = 1'b1; hresp = 2'b00; hrdata = 32'h0;
        step();
        step();
        check_reset_values("rst");
        resetn = 1'b1;
        step();

        // 1: word read, grant and ready always high
        hrdata = 32'hDEAD_BEEF;
        issue(1'b0, 1'b1, 32'h0000_0100, 32'h0, 3'h2, 4'h0, 1'b0);
        step();
        check_eq("t1_req_busreq", 32'(hbusreq), 32'h1);
        check_eq("t1_req_htrans", 32'(htrans), 32'h0);
        step();
        check_eq("t1_addr_htrans", 32'(htrans), 32'h2);
        check_eq("t1_addr_haddr", haddr, 32'h0000_0100);
        check_eq("t1_addr_hsize", 32'(hsize), 32'h2);
        check_eq("t1_addr_hwrite", 32'(hwrite), 32'h0);
        check_eq("t1_addr_hburst", 32'(hburst), 32'h0);
        check_eq("t1_addr_hprot", 32'(hprot), 32'h2);
        step();
        check_eq("t1_data_htrans", 32'(htrans), 32'h0);
        check_eq("t1_data_busreq", 32'(hbusreq), 32'h0);
        check_eq("t1_data_ready", 32'(mem_ahb_ready), 32'h0);
        step();
        check_eq("t1_done_ready", 32'(mem_ahb_ready), 32'h1);
        check_eq("t1_done_rdata", mem_ahb_rdata, 32'hDEAD_BEEF);
        check_eq("t1_done_err", 32'(mem_ahb_err), 32'h0);
        mem_ahb_valid = 1'b0;
        step();
        check_eq("t1_after_ready", 32'(mem_ahb_ready), 32'h0);
        check_eq("t1_after_rdata", mem_ahb_rdata, 32'hDEAD_BEEF);

        // 2: locked byte write, grant late by 3 cycles, 2 data-phase wait states
        hgrant = 1'b0;
        hrdata = 32'h1234_5678;
        issue(1'b1, 1'b0, 32'h0000_0203, 32'hA500_0000, 3'h0, 4'h1, 1'b1);
        step();
        check_eq("t2_c1_busreq", 32'(hbusreq), 32'h1);
        check_eq("t2_c1_hlock", 32'(hlock), 32'h1);
        for (int c = 2; c <= 4; c++) begin
            step();
            check_eq("t2_wait_busreq", 32'(hbusreq), 32'h1);
            check_eq("t2_wait_htrans", 32'(htrans), 32'h0);
        end
        hgrant = 1'b1;
        step();
        check_eq("t2_addr_htrans", 32'(htrans), 32'h2);
        check_eq("t2_addr_haddr", haddr, 32'h0000_0203);
        check_eq("t2_addr_hsize", 32'(hsize), 32'h0);
        check_eq("t2_addr_hwrite", 32'(hwrite), 32'h1);
        check_eq("t2_addr_hprot", 32'(hprot), 32'h3);
        step();
        check_eq("t2_data_hwdata", hwdata, 32'hA500_0000);
        check_eq("t2_data_busreq", 32'(hbusreq), 32'h0);
        hready = 1'b0;
        for (int c = 7; c <= 8; c++) begin
            step();
            check_eq("t2_ws_hwdata", hwdata, 32'hA500_0000);
            check_eq("t2_ws_htrans", 32'(htrans), 32'h0);
            check_eq("t2_ws_ready", 32'(mem_ahb_ready), 32'h0);
        end
        hready = 1'b1;
        step();
        check_eq("t2_c9_ready", 32'(mem_ahb_ready), 32'h1);
        check_eq("t2_c9_err", 32'(mem_ahb_err), 32'h0);
        check_eq("t2_c9_rdata_kept", mem_ahb_rdata, 32'hDEAD_BEEF);
        mem_ahb_valid = 1'b0;
        step();

        // 3: misaligned half-word read
        issue(1'b0, 1'b1, 32'h0000_0001, 32'h0, 3'h1, 4'h0, 1'b0);
        step();
        check_eq("t3_ready", 32'(mem_ahb_ready), 32'h1);
        check_eq("t3_err", 32'(mem_ahb_err), 32'h1);
        check_eq("t3_busreq", 32'(hbusreq), 32'h0);
        check_eq("t3_htrans", 32'(htrans), 32'h0);
        mem_ahb_valid = 1'b0;
        step();
        check_eq("t3_after_ready", 32'(mem_ahb_ready), 32'h0);
        check_eq("t3_after_busreq", 32'(hbusreq), 32'h0);

        // 4: word read answered with two-cycle ERROR
        hrdata = 32'hBAD0_BAD0;
        issue(1'b0, 1'b1, 32'h0000_0200, 32'h0, 3'h2, 4'h0, 1'b0);
        step();
        step();
        check_eq("t4_addr_htrans", 32'(htrans), 32'h2);
        step();
        check_eq("t4_data_htrans", 32'(htrans), 32'h0);
        hready = 1'b0; hresp = 2'b01;
        step();
        check_eq("t4_resp1_htrans", 32'(htrans), 32'h0);
        check_eq("t4_resp1_ready", 32'(mem_ahb_ready), 32'h0);
        hready = 1'b1;
        step();
        check_eq("t4_ready", 32'(mem_ahb_ready), 32'h1);
        check_eq("t4_err", 32'(mem_ahb_err), 32'h1);
        check_eq("t4_rdata_kept", mem_ahb_rdata, 32'hDEAD_BEEF);
        check_eq("t4_htrans", 32'(htrans), 32'h0);
        mem_ahb_valid = 1'b0; hresp = 2'b00;
        step();

        // 5a: RETRY twice, OKAY on the third attempt
        hrdata = 32'hCAFE_F00D;
        issue(1'b0, 1'b1, 32'h0000_0300, 32'h0, 3'h2, 4'h0, 1'b0);
        step();
        check_eq("t5a_req_busreq", 32'(hbusreq), 32'h1);
        attempt(2'b10, 32'h0000_0300);
        check_eq("t5a_r1_busreq", 32'(hbusreq), 32'h1);
        check_eq("t5a_r1_ready", 32'(mem_ahb_ready), 32'h0);
        attempt(2'b10, 32'h0000_0300);
        check_eq("t5a_r2_busreq", 32'(hbusreq), 32'h1);
        check_eq("t5a_r2_ready", 32'(mem_ahb_ready), 32'h0);
        attempt(2'b00, 32'h0000_0300);
        check_eq("t5a_ready", 32'(mem_ahb_ready), 32'h1);
        check_eq("t5a_err", 32'(mem_ahb_err), 32'h0);
        check_eq("t5a_rdata", mem_ahb_rdata, 32'hCAFE_F00D);
        mem_ahb_valid = 1'b0;
        step();

        // 5b: RETRY, SPLIT with grant withdrawn, then RETRY beyond the limit
        hrdata = 32'h1111_1111;
        issue(1'b0, 1'b1, 32'h0000_0304, 32'h0, 3'h2, 4'h0, 1'b0);
        step();
        attempt(2'b10, 32'h0000_0304);
        check_eq("t5b_r1_busreq", 32'(hbusreq), 32'h1);
        attempt(2'b11, 32'h0000_0304);
        check_eq("t5b_split_ready", 32'(mem_ahb_ready), 32'h0);
        hgrant = 1'b0;
        step();
        check_eq("t5b_split_busreq", 32'(hbusreq), 32'h1);
        check_eq("t5b_split_htrans", 32'(htrans), 32'h0);
        hgrant = 1'b1;
        attempt(2'b10, 32'h0000_0304);
        check_eq("t5b_ready", 32'(mem_ahb_ready), 32'h1);
        check_eq("t5b_err", 32'(mem_ahb_err), 32'h1);
        check_eq("t5b_rdata_kept", mem_ahb_rdata, 32'hCAFE_F00D);
        mem_ahb_valid = 1'b0;
        step();

        // 6: reset during DATA, then a normal read
        hrdata = 32'h5555_AAAA;
        issue(1'b0, 1'b1, 32'h0000_0400, 32'h0, 3'h2, 4'h0, 1'b0);
        step();
        step();
        step();
        check_eq("t6_data_htrans", 32'(htrans), 32'h0);
        hready = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        check_reset_values("t6_rst");
        step();
        check_eq("t6_rst_ready", 32'(mem_ahb_ready), 32'h0);
        resetn = 1'b1;
        hready = 1'b1;
        step();
        check_eq("t6_req_busreq", 32'(hbusreq), 32'h1);
        step();
        check_eq("t6_addr_haddr", haddr, 32'h0000_0400);
        check_eq("t6_addr_htrans", 32'(htrans), 32'h2);
        step();
        check_eq("t6_data_ready", 32'(mem_ahb_ready), 32'h0);
        step();
        check_eq("t6_ready", 32'(mem_ahb_ready), 32'h1);
        check_eq("t6_rdata", mem_ahb_rdata, 32'h5555_AAAA);
        check_eq("t6_err", 32'(mem_ahb_err), 32'h0);
        mem_ahb_valid = 1'b0;
        step();
        check_eq("t6_after_ready", 32'(mem_ahb_ready), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
